// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional halt feature is enabled by defining FETCH_HALT_EN.
package fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned JT_W  = 26;
  localparam int unsigned OP_W  = 6;

  // Opcode that stops fetching when the halt feature is built in
  localparam logic [OP_W-1:0] HALT_OP = 6'b111111;

  // Next-PC source select
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_REG    = 2'b11
  } pc_src_e;

  // Fetch controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_VALID = 3'd2,
    ST_ERR   = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // Redirect request presented by the decoder on a handshake
  typedef struct packed {
    logic             redirect;
    pc_src_e          src;
    logic [XLEN-1:0]  branch_off;
    logic [JT_W-1:0]  jump_tgt;
    logic [XLEN-1:0]  reg_tgt;
  } redirect_req_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection plus alignment/range check against the
// instruction memory size.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic [XLEN-1:0] pc4_i,
  input  redirect_req_t   req_i,
  output logic [XLEN-1:0] next_pc_c_o,
  output logic            addr_err_c_o
);

  // Highest byte address at which a full word still fits in memory
  localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(MEM_BYTES - 4);

  // Select the next PC; only a redirect may leave the sequential path
  always_comb begin
    next_pc_c_o = pc4_i;
    if (req_i.redirect) begin
      case (req_i.src)
        PCSRC_BRANCH: next_pc_c_o = pc4_i + (req_i.branch_off << 2);
        PCSRC_JUMP:   next_pc_c_o = {pc4_i[XLEN-1:28], req_i.jump_tgt, 2'b00};
        PCSRC_REG:    next_pc_c_o = req_i.reg_tgt;
        default:      next_pc_c_o = pc4_i;
      endcase
    end
  end

  // Flag misaligned or out-of-memory targets
  always_comb begin
    addr_err_c_o = (|next_pc_c_o[1:0]) || (next_pc_c_o > LAST_ADDR);
  end

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: two-cycle fetch/present loop with decoder
// handshake, PC redirect, sticky address fault and optional halt opcode
// (enabled by defining FETCH_HALT_EN).
module ins_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic             CLK,
  input  logic             Reset,
  output logic             InsMemRW,
  output logic [XLEN-1:0]  InsAddr,
  input  logic [XLEN-1:0]  readIns,
  output logic [XLEN-1:0]  IR,
  output logic [XLEN-1:0]  CurPC,
  output logic [XLEN-1:0]  PC4,
  output logic             InsValid,
  input  logic             DecReady,
  input  logic             Redirect,
  input  logic [1:0]       PCSrc,
  input  logic [XLEN-1:0]  BranchOffset,
  input  logic [JT_W-1:0]  JumpTarget,
  input  logic [XLEN-1:0]  RegTarget,
  output logic             AddrErr,
  output logic             Halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] curpc_q, curpc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            memrw_q, memrw_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
`ifdef FETCH_HALT_EN
  logic            halted_q, halted_d;
`endif

  redirect_req_t   req;
  logic [XLEN-1:0] npc;
  logic            npc_err;

  // Bundle redirect inputs for the next-PC calculator
  always_comb begin
    req.redirect   = Redirect;
    req.src        = pc_src_e'(PCSrc);
    req.branch_off = BranchOffset;
    req.jump_tgt   = JumpTarget;
    req.reg_tgt    = RegTarget;
  end

  next_pc_calc #(
    .MEM_BYTES (MEM_BYTES)
  ) u_next_pc_calc (
    .pc4_i        (pc4_q),
    .req_i        (req),
    .next_pc_c_o  (npc),
    .addr_err_c_o (npc_err)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update; redirect inputs only matter on a handshake
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    curpc_d = curpc_q;
    pc4_d   = pc4_q;
    err_d   = err_q;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = readIns;
        curpc_d = pc_q;
        pc4_d   = pc_q + XLEN'(4);
        state_d = ST_VALID;
      end
      ST_VALID: begin
        if (DecReady) begin
`ifdef FETCH_HALT_EN
          if (ir_q[XLEN-1 -: OP_W] == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else
`endif
          if (npc_err) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            pc_d    = npc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_ERR:  state_d = ST_ERR;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    memrw_d = (state_d == ST_FETCH);
    valid_d = (state_d == ST_VALID);
  end

  // Datapath and output registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      curpc_q  <= '0;
      pc4_q    <= '0;
      memrw_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      curpc_q  <= curpc_d;
      pc4_q    <= pc4_d;
      memrw_q  <= memrw_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef FETCH_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign InsMemRW = memrw_q;
  assign InsAddr  = pc_q;
  assign IR       = ir_q;
  assign CurPC    = curpc_q;
  assign PC4      = pc4_q;
  assign InsValid = valid_q;
  assign AddrErr  = err_q;
`ifdef FETCH_HALT_EN
  assign Halted   = halted_q;
`else
  assign Halted   = 1'b0;
`endif

endmodule
